// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave memory arbiter with a single outstanding
// transaction and a response watchdog. Define ARB_RR_EN for round-robin arbitration (default: LSU priority).
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    logic                owner_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                wen_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [MASK_W-1:0]   wmask_r;
    logic [CNT_W-1:0]    cnt_r;
`ifdef ARB_RR_EN
    logic                last_served_r;
`endif

    logic                ifu_win_s;
    logic                lsu_win_s;
    logic                busy_s;
    logic                rsp_hit_s;
    logic                timeout_s;
    logic                rsp_fire_s;
    logic [DATA_W-1:0]   rsp_data_s;
    logic                rsp_err_s;

    // Arbitration between the two masters (evaluated every cycle, used only in IDLE)
    always_comb begin
        ifu_win_s = 1'b0;
        lsu_win_s = 1'b0;
`ifdef ARB_RR_EN
        if (ifu_req_valid && lsu_req_valid) begin
            lsu_win_s = (last_served_r == OWN_IFU);
            ifu_win_s = (last_served_r == OWN_LSU);
        end else begin
            lsu_win_s = lsu_req_valid;
            ifu_win_s = ifu_req_valid;
        end
`else
        lsu_win_s = lsu_req_valid;
        ifu_win_s = ifu_req_valid && !lsu_req_valid;
`endif
    end

    assign busy_s     = (state_r != ST_IDLE);
    assign rsp_hit_s  = (state_r == ST_WAIT) && mem_rsp_valid;
    // A real response in the last allowed cycle beats the watchdog
    assign timeout_s  = WDOG_EN && busy_s && (cnt_r == CNT_LAST) && !rsp_hit_s;
    assign rsp_fire_s = rsp_hit_s || timeout_s;

    // Response payload shared by both masters; zero whenever no response is issued
    always_comb begin
        rsp_data_s = {DATA_W{1'b0}};
        rsp_err_s  = 1'b0;
        if (!rsp_fire_s) begin
            rsp_data_s = {DATA_W{1'b0}};
            rsp_err_s  = 1'b0;
        end else if (timeout_s) begin
            rsp_data_s = {DATA_W{1'b0}};
            rsp_err_s  = 1'b1;
        end else if (owner_r == OWN_LSU && wen_r) begin
            rsp_data_s = {DATA_W{1'b0}};
            rsp_err_s  = mem_rsp_err;
        end else begin
            rsp_data_s = mem_rsp_data;
            rsp_err_s  = mem_rsp_err;
        end
    end

    assign ifu_req_ready = rst && (state_r == ST_IDLE) && ifu_win_s;
    assign lsu_req_ready = rst && (state_r == ST_IDLE) && lsu_win_s;

    assign ifu_rsp_valid = rsp_fire_s && (owner_r == OWN_IFU);
    assign ifu_rsp_data  = (owner_r == OWN_IFU) ? rsp_data_s : {DATA_W{1'b0}};
    assign ifu_rsp_err   = (owner_r == OWN_IFU) && rsp_err_s;
    assign lsu_rsp_valid = rsp_fire_s && (owner_r == OWN_LSU);
    assign lsu_rsp_data  = (owner_r == OWN_LSU) ? rsp_data_s : {DATA_W{1'b0}};
    assign lsu_rsp_err   = (owner_r == OWN_LSU) && rsp_err_s;

    assign mem_req_valid = (state_r == ST_REQ) && !timeout_s;
    assign mem_addr      = addr_r;
    assign mem_wen       = wen_r;
    assign mem_wdata     = wdata_r;
    assign mem_wmask     = wmask_r;
    assign busy          = busy_s;

    // Sequencer FSM: latches the granted request, drives the slave, and runs the watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_IFU;
            addr_r  <= {ADDR_W{1'b0}};
            wen_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {MASK_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
`ifdef ARB_RR_EN
            last_served_r <= OWN_LSU;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lsu_win_s || ifu_win_s) begin
                        state_r <= ST_REQ;
                        owner_r <= lsu_win_s;
                        cnt_r   <= {CNT_W{1'b0}};
`ifdef ARB_RR_EN
                        last_served_r <= lsu_win_s;
`endif
                        if (lsu_win_s) begin
                            addr_r  <= lsu_addr;
                            wen_r   <= lsu_wen;
                            wdata_r <= lsu_wdata;
                            wmask_r <= lsu_wmask;
                        end else begin
                            addr_r  <= ifu_addr;
                            wen_r   <= 1'b0;
                            wdata_r <= {DATA_W{1'b0}};
                            wmask_r <= {MASK_W{1'b0}};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (timeout_s) begin
                        state_r <= ST_IDLE;
                    end else if (mem_req_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (rsp_fire_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter built with an 8-cycle watchdog; expectations follow ARB_RR_EN.
module tb_mem_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [3:0]  mem_wmask;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IFU read that is started now; slave ready in ready_cyc (0 = never), optional reply in cycle 8
    task automatic run_wd(input int ready_cyc, input logic reply, input logic [31:0] d);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0008;
        #1;
        tick();
        ifu_req_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            mem_req_ready = (k == ready_cyc);
            #1;
            check_eq("wd_quiet", {63'd0, ifu_rsp_valid}, 64'd0);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = reply;
        mem_rsp_data  = d;
        mem_rsp_err   = 1'b0;
        #1;
        check_eq("wd_valid", {63'd0, ifu_rsp_valid}, 64'd1);
        check_eq("wd_err", {63'd0, ifu_rsp_err}, reply ? 64'd0 : 64'd1);
        check_eq("wd_data", {32'd0, ifu_rsp_data}, reply ? {32'd0, d} : 64'd0);
        check_eq("wd_memvalid", {63'd0, mem_req_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("wd_idle", {63'd0, busy}, 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0055;
        #1;
        check_eq("wd_stray", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic exp_lsu;
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = 32'd0;
        lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        check_eq("rst_valid", {61'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        check_eq("rst_addr", {32'd0, mem_addr}, 64'd0);
        rst = 1'b1;
        tick();

        // IFU read
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000;
        #1;
        check_eq("ifu_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        check_eq("req_valid", {63'd0, mem_req_valid}, 64'd1);
        check_eq("req_addr", {32'd0, mem_addr}, 64'h8000_0000);
        check_eq("req_wen_mask", {59'd0, mem_wen, mem_wmask}, 64'd0);
        check_eq("req_busy", {63'd0, busy}, 64'd1);
        check_eq("rsp_early", {63'd0, ifu_rsp_valid}, 64'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0093;
        mem_rsp_err   = 1'b0;
        #1;
        check_eq("wait_reqv", {63'd0, mem_req_valid}, 64'd0);
        check_eq("ifu_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd2);
        check_eq("ifu_data", {32'd0, ifu_rsp_data}, 64'h0010_0093);
        check_eq("ifu_err", {63'd0, ifu_rsp_err}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("rsp_once", {63'd0, ifu_rsp_valid}, 64'd0);
        check_eq("back_idle", {63'd0, busy}, 64'd0);

        // Contention, LSU write, then 5 cycles of slave backpressure
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        check_eq("cont_grant", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_wdata = 32'h1111_1111; lsu_addr = 32'h0; lsu_wmask = 4'h0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", {63'd0, mem_req_valid}, 64'd1);
            check_eq("bp_addr", {32'd0, mem_addr}, 64'h8000_1000);
            check_eq("bp_wdata", {31'd0, mem_wen, mem_wdata}, 64'h1_DEAD_BEEF);
            check_eq("bp_wmask", {60'd0, mem_wmask}, 64'hF);
            check_eq("bp_noacc", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        #1;
        check_eq("wr_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd1);
        check_eq("wr_data0", {32'd0, lsu_rsp_data}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("ifu_next", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        check_eq("ifu2_addr", {32'd0, mem_addr}, 64'h8000_0004);
        check_eq("ifu2_forced", {59'd0, mem_wen, mem_wmask}, 64'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D; mem_rsp_err = 1'b1;
        #1;
        check_eq("slv_err", {31'd0, ifu_rsp_err, ifu_rsp_data}, 64'h1_CAFE_F00D);
        tick();
        mem_rsp_err = 1'b0;
        #1;
        check_eq("stale_rsp", {61'd0, busy, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        tick();
        mem_rsp_valid = 1'b0;

        // Reset in the middle of WAIT
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000;
        #1;
        tick();
        ifu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check_eq("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_rdy", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        check_eq("arst_val", {61'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        lsu_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        ifu_addr = 32'h8000_0000;
        #1;
        check_eq("post_rst_rdy", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);

        // Four back-to-back contended transactions
        lsu_req_valid = 1'b1; lsu_wen = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_lsu = RR ? (i % 2 == 1) : 1'b1;
            check_eq("rr_grant", {62'd0, ifu_req_ready, lsu_req_ready}, {62'd0, !exp_lsu, exp_lsu});
            tick();
            check_eq("rr_wen", {63'd0, mem_wen}, {63'd0, exp_lsu});
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            #1;
            check_eq("rr_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, {62'd0, !exp_lsu, exp_lsu});
            tick();
            mem_rsp_valid = 1'b0;
            #1;
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();

        // Watchdog: timeout in WAIT, timeout while slave never accepts, reply in the last cycle
        run_wd(3, 1'b0, 32'd0);
        run_wd(0, 1'b0, 32'd0);
        run_wd(1, 1'b1, 32'h0BAD_C0DE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
